// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
// No logic of its own; zero latency.
// No handshake; pure compile-time definitions.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of clock steps needed to consume a width-bit operand digit by digit
  function automatic int steps(input int width, input int digit);
    return width / digit;
  endfunction

  // Step counter width; a single-step adder still needs a one-bit counter
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_digit.sv
// DIGIT-bit ripple-carry slice built from chained full-adder bit cells.
// Purely combinational, zero latency.
// No handshake; the caller registers inputs and outputs.
module adder_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: A+B+cin processed DIGIT bits per clock, flags cout and ovf.
// Result valid exactly STEPS cycles after the operand handshake edge.
// One operation in flight; result held in DONE until out_ready, in_ready low meanwhile.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  import adder_pkg::*;

  localparam int STEPS = steps(WIDTH, DIGIT);
  localparam int CW    = cnt_width(STEPS);

  if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_nxt;
  logic [WIDTH-1:0] s_ext;
  logic             carry;
  logic             a_msb;
  logic             b_msb;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [DIGIT-1:0] slice_s;
  logic             slice_co;

  assign last = (cnt == CW'(STEPS - 1));

  adder_digit #(.DIGIT(DIGIT)) u_digit (
    .a  (a_sh[DIGIT-1:0]),
    .b  (b_sh[DIGIT-1:0]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  // New digit enters at the top so after STEPS shifts the LSB digit sits at bit 0.
  // Written with shifts so DIGIT == WIDTH needs no special case.
  assign s_ext   = WIDTH'(slice_s);
  assign sum_nxt = (s_ext << (WIDTH - DIGIT)) | (sum_sh >> DIGIT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operand capture, digit-serial accumulation and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= in_a;
            b_sh  <= in_b;
            carry <= cin;
            a_msb <= in_a[WIDTH-1];
            b_msb <= in_b[WIDTH-1];
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          sum_sh <= sum_nxt;
          carry  <= slice_co;
          cnt    <= cnt + CW'(1);
          if (last) begin
            sum  <= sum_nxt;
            cout <= slice_co;
            ovf  <= (a_msb == b_msb) && (sum_nxt[WIDTH-1] != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder across four WIDTH/DIGIT configurations.
// Drives inputs #1 after the rising edge and samples outputs at the same point.
// All four instances share the operand bus; only one is handed in_valid at a time.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_cin;
  logic        out_ready;
  logic        in_valid  [4];
  logic        in_ready  [4];
  logic        out_valid [4];
  logic        cout      [4];
  logic        ovf       [4];
  logic [7:0]  s0, s1, s3;
  logic [15:0] s2;
  logic [15:0] sumx      [4];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sumx[0] = {8'h00, s0};
  assign sumx[1] = {8'h00, s1};
  assign sumx[2] = s2;
  assign sumx[3] = {8'h00, s3};

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(op_a[7:0]), .in_b(op_b[7:0]), .cin(op_cin), .out_valid(out_valid[0]),
    .out_ready(out_ready), .sum(s0), .cout(cout[0]), .ovf(ovf[0]));

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(op_a[7:0]), .in_b(op_b[7:0]), .cin(op_cin), .out_valid(out_valid[1]),
    .out_ready(out_ready), .sum(s1), .cout(cout[1]), .ovf(ovf[1]));

  serial_adder #(.WIDTH(16), .DIGIT(2)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_a(op_a), .in_b(op_b), .cin(op_cin), .out_valid(out_valid[2]),
    .out_ready(out_ready), .sum(s2), .cout(cout[2]), .ovf(ovf[2]));

  serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_a(op_a[7:0]), .in_b(op_b[7:0]), .cin(op_cin), .out_valid(out_valid[3]),
    .out_ready(out_ready), .sum(s3), .cout(cout[3]), .ovf(ovf[3]));

  typedef struct {
    int          k;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [15:0] s;
    logic        co;
    logic        ov;
    int          lat;
  } vec_t;

  // Hand one operand set to instance k and wait (bounded) for its result.
  // acc is the cycle count just after the acceptance edge.
  task automatic do_add(input int k, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input bit release_out,
                        output logic [15:0] s, output logic co, output logic ov,
                        output int lat, output int acc);
    int w;
    w = 0;
    while (in_ready[k] !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    op_a = a; op_b = b; op_cin = c; in_valid[k] = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    in_valid[k] = 1'b0;
    lat = 0;
    while (out_valid[k] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    s = sumx[k]; co = cout[k]; ov = ovf[k];
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    op_a = '0; op_b = '0; op_cin = 1'b0;
    for (int k = 0; k < 4; k++) in_valid[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (in_ready[k] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready[%0d]: got %b want 1", k, in_ready[k]); end
      n_checks++; if (out_valid[k] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d]: got %b want 0", k, out_valid[k]); end
      n_checks++; if (sumx[k] !== 16'h0000) begin n_fail++; $display("FAIL reset_sum[%0d]: got %h want 0000", k, sumx[k]); end
      n_checks++; if (cout[k] !== 1'b0) begin n_fail++; $display("FAIL reset_cout[%0d]: got %b want 0", k, cout[k]); end
      n_checks++; if (ovf[k] !== 1'b0) begin n_fail++; $display("FAIL reset_ovf[%0d]: got %b want 0", k, ovf[k]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    vec_t        t [12];
    logic [15:0] s;
    logic        co, ov;
    int          lat, acc;
    t[0]  = '{0, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 8};
    t[1]  = '{0, 16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b1, 8};
    t[2]  = '{0, 16'h0080, 16'h0080, 1'b0, 16'h0000, 1'b1, 1'b1, 8};
    t[3]  = '{1, 16'h00A5, 16'h005A, 1'b1, 16'h0000, 1'b1, 1'b0, 2};
    t[4]  = '{1, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 2};
    t[5]  = '{1, 16'h007F, 16'h007F, 1'b1, 16'h00FF, 1'b0, 1'b1, 2};
    t[6]  = '{2, 16'h1234, 16'hEDCB, 1'b1, 16'h0000, 1'b1, 1'b0, 8};
    t[7]  = '{2, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 8};
    t[8]  = '{2, 16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 8};
    t[9]  = '{3, 16'h0064, 16'h0064, 1'b0, 16'h00C8, 1'b0, 1'b1, 1};
    t[10] = '{3, 16'h00FF, 16'h00FF, 1'b1, 16'h00FF, 1'b1, 1'b0, 1};
    t[11] = '{3, 16'h0012, 16'h0034, 1'b0, 16'h0046, 1'b0, 1'b0, 1};
    for (int i = 0; i < 12; i++) begin
      do_add(t[i].k, t[i].a, t[i].b, t[i].c, 1'b1, s, co, ov, lat, acc);
      n_checks++; if (s !== t[i].s) begin n_fail++; $display("FAIL vec%0d_sum: got %h want %h", i, s, t[i].s); end
      n_checks++; if (co !== t[i].co) begin n_fail++; $display("FAIL vec%0d_cout: got %b want %b", i, co, t[i].co); end
      n_checks++; if (ov !== t[i].ov) begin n_fail++; $display("FAIL vec%0d_ovf: got %b want %b", i, ov, t[i].ov); end
      n_checks++; if (lat != t[i].lat) begin n_fail++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, t[i].lat); end
    end
  endtask

  // 0x70 + 0x20 + 1 = 0x91: positive operands, negative result, no carry.
  task automatic test_backpressure();
    logic [15:0] s;
    logic        co, ov;
    int          lat, acc;
    do_add(0, 16'h0070, 16'h0020, 1'b1, 1'b0, s, co, ov, lat, acc);
    n_checks++; if (lat != 8) begin n_fail++; $display("FAIL bp_latency: got %0d want 8", lat); end
    for (int i = 0; i < 5; i++) begin
      op_a = 16'h0011 * 16'(i + 1); op_b = 16'h0003; op_cin = 1'b0;
      in_valid[0] = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid c%0d: got %b want 1", i, out_valid[0]); end
      n_checks++; if (in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c%0d: got %b want 0", i, in_ready[0]); end
      n_checks++; if (sumx[0] !== 16'h0091) begin n_fail++; $display("FAIL bp_sum c%0d: got %h want 0091", i, sumx[0]); end
      n_checks++; if (cout[0] !== 1'b0) begin n_fail++; $display("FAIL bp_cout c%0d: got %b want 0", i, cout[0]); end
      n_checks++; if (ovf[0] !== 1'b1) begin n_fail++; $display("FAIL bp_ovf c%0d: got %b want 1", i, ovf[0]); end
    end
    in_valid[0] = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid[0]); end
    n_checks++; if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready[0]); end
    @(posedge clk); #1;
    n_checks++; if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL bp_idle_stays: got %b want 1", in_ready[0]); end
    n_checks++; if (sumx[0] !== 16'h0091) begin n_fail++; $display("FAIL bp_sum_held_idle: got %h want 0091", sumx[0]); end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] s;
    logic        co, ov;
    int          lat, acc;
    bit          seen;
    op_a = 16'h0055; op_b = 16'h0022; op_cin = 1'b1;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready[0]); end
    n_checks++; if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid[0]); end
    n_checks++; if (sumx[0] !== 16'h0000) begin n_fail++; $display("FAIL midrst_sum: got %h want 0000", sumx[0]); end
    n_checks++; if (cout[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_cout: got %b want 0", cout[0]); end
    n_checks++; if (ovf[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_ovf: got %b want 0", ovf[0]); end
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid[0] === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL midrst_no_partial: got out_valid 1 want 0"); end
    do_add(0, 16'h0012, 16'h0034, 1'b0, 1'b1, s, co, ov, lat, acc);
    n_checks++; if (s !== 16'h0046) begin n_fail++; $display("FAIL midrst_fresh_sum: got %h want 0046", s); end
    n_checks++; if (lat != 8) begin n_fail++; $display("FAIL midrst_fresh_latency: got %0d want 8", lat); end
  endtask

  // DIGIT=4 on 8 bits: acceptances spaced STEPS+2 = 4 cycles apart.
  task automatic test_back_to_back();
    logic [15:0] s;
    logic        co, ov;
    int          lat, acc0, acc1;
    do_add(1, 16'h0011, 16'h0022, 1'b0, 1'b1, s, co, ov, lat, acc0);
    n_checks++; if (s !== 16'h0033) begin n_fail++; $display("FAIL b2b_first_sum: got %h want 0033", s); end
    do_add(1, 16'h00F0, 16'h0020, 1'b0, 1'b1, s, co, ov, lat, acc1);
    n_checks++; if (s !== 16'h0010 || co !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got %h/%b want 0010/1", s, co); end
    n_checks++; if (acc1 - acc0 != 4) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 4", acc1 - acc0); end
  endtask

  task automatic test_sweep();
    logic [15:0] a, b, s, es;
    logic        c, co, ov, eco, eov;
    logic [16:0] full;
    int          k, lat, acc;
    for (int n = 0; n < 200; n++) begin
      k = n % 4;
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      if (k != 2) begin a = a & 16'h00FF; b = b & 16'h00FF; end
      full = {1'b0, a} + {1'b0, b} + 17'(c);
      if (k == 2) begin
        es = full[15:0]; eco = full[16];
        eov = (a[15] == b[15]) && (es[15] != a[15]);
      end else begin
        es = {8'h00, full[7:0]}; eco = full[8];
        eov = (a[7] == b[7]) && (full[7] != a[7]);
      end
      do_add(k, a, b, c, 1'b1, s, co, ov, lat, acc);
      n_checks++;
      if (s !== es || co !== eco || ov !== eov) begin
        n_fail++;
        $display("FAIL sweep%0d inst%0d %h+%h+%b: got %h/%b/%b want %h/%b/%b", n, k, a, b, c, s, co, ov, es, eco, eov);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
